// File: rtl/reflet_pwm_pkg.sv
// Shared definitions for the Reflet multi-channel PWM.
//
// Contents:
//   PWM_MODE_EDGE / PWM_MODE_CENTER : encodings of the 1-bit mode input.
//   pwm_dir_e                       : counting direction of the shared counter.
//   pwm_period_ticks()              : period length in ticks for a given mode/max.
//
// Optional build macro used by the top level: REFLET_PWM_MULTI_DEADTIME_EN.
package reflet_pwm_pkg;

   localparam logic PWM_MODE_EDGE   = 1'b0;
   localparam logic PWM_MODE_CENTER = 1'b1;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } pwm_dir_e;

   // Number of ticks in one PWM period. A zero top count collapses every
   // period to a single tick in both modes.
   function automatic int unsigned pwm_period_ticks(input logic mode, input int unsigned max_count);
      if (max_count == 0) begin
         return 1;
      end else if (mode == PWM_MODE_CENTER) begin
         return 2 * max_count;
      end else begin
         return max_count + 1;
      end
   endfunction

endpackage

// File: rtl/reflet_pwm_multi_deadtime.sv
// Dead-time insertion for one PWM channel.
//
// Delays every rising edge of the true output (out_o) and of the
// complementary output (out_n_o) by dead_time_i clock cycles. Falling edges
// are immediate, so the two outputs are never high at the same time. A
// level that lasts fewer than dead_time_i cycles never reaches either pin.
//
// Ports:
//   clk         : system clock
//   reset       : synchronous active-high reset, clears both outputs
//   pwm_i       : next-cycle raw PWM level (already polarity-adjusted)
//   dead_time_i : rising-edge delay in clk cycles, 0 = pure complement
//   out_o       : delayed true output, registered
//   out_n_o     : delayed complementary output, registered
module reflet_pwm_multi_deadtime #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pwm_i,
   input  logic [WIDTH-1:0] dead_time_i,
   output logic             out_o,
   output logic             out_n_o
);

   logic             level_q, level_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             out_q, out_d;
   logic             out_n_q, out_n_d;

   always_comb begin
      level_d = level_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      out_n_d = out_n_q;
      if (pwm_i != level_q) begin
         // Level change: the side that was high drops now; the side that
         // becomes high waits out the dead time (restarting on every change,
         // which is what swallows short pulses).
         level_d = pwm_i;
         if (dead_time_i == '0) begin
            cnt_d   = '0;
            out_d   = pwm_i;
            out_n_d = ~pwm_i;
         end else begin
            cnt_d   = dead_time_i;
            out_d   = 1'b0;
            out_n_d = 1'b0;
         end
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
         if (cnt_q == WIDTH'(1)) begin
            out_d   = level_q;
            out_n_d = ~level_q;
         end
      end else begin
         out_d   = level_q;
         out_n_d = ~level_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         level_q <= 1'b0;
         cnt_q   <= '0;
         out_q   <= 1'b0;
         out_n_q <= 1'b0;
      end else begin
         level_q <= level_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
         out_n_q <= out_n_d;
      end
   end

   assign out_o   = out_q;
   assign out_n_o = out_n_q;

endmodule

// File: rtl/reflet_pwm_multi.sv
// Multi-channel PWM generator.
//
// All channels share one prescaled counter, one top count (max) and one
// counting mode; each channel has its own duty cycle and polarity. Mode, max
// and duty are shadowed: they are copied into the active registers only at a
// period boundary (counter 0, counting up) and only when an update has been
// requested, so an output never glitches mid-period. Polarity is applied
// directly on the next tick.
//
// Ports:
//   clk        : system clock
//   reset      : synchronous active-high reset
//   enable     : 1 = counter runs, 0 = everything frozen
//   mode       : 0 = edge-aligned, 1 = center-aligned (shadowed)
//   prescale   : counter advances once every prescale+1 enabled clocks
//   max        : top count (shadowed)
//   duty_cycle : channel i duty at [i*WIDTH +: WIDTH] (shadowed)
//   polarity   : per-channel output inversion
//   update     : request to load the shadowed inputs at the next boundary
//   out        : PWM outputs, registered
//   period_end : one-cycle pulse for the tick that completes a period
//   dead_time  : (REFLET_PWM_MULTI_DEADTIME_EN only) rising-edge delay
//   out_n      : (REFLET_PWM_MULTI_DEADTIME_EN only) complementary outputs
//
// Build option: define REFLET_PWM_MULTI_DEADTIME_EN to add complementary
// outputs with dead-time insertion.
module reflet_pwm_multi
   import reflet_pwm_pkg::*;
#(
   parameter int WIDTH          = 8,
   parameter int CHANNELS       = 4,
   parameter int PRESCALE_WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      enable,
   input  logic                      mode,
   input  logic [PRESCALE_WIDTH-1:0] prescale,
   input  logic [WIDTH-1:0]          max,
   input  logic [CHANNELS*WIDTH-1:0] duty_cycle,
   input  logic [CHANNELS-1:0]       polarity,
   input  logic                      update,
   output logic [CHANNELS-1:0]       out,
   output logic                      period_end
`ifdef REFLET_PWM_MULTI_DEADTIME_EN
   ,
   input  logic [WIDTH-1:0]          dead_time,
   output logic [CHANNELS-1:0]       out_n
`endif
);

   // Prescaler and shared counter
   logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
   logic [WIDTH-1:0]          cnt_q, cnt_d;
   pwm_dir_e                  dir_q, dir_d;

   // Active (post-shadow) configuration
   logic                      mode_q, mode_d;
   logic [WIDTH-1:0]          max_q, max_d;
   logic [CHANNELS*WIDTH-1:0] duty_q, duty_d;
   logic                      pending_q, pending_d;

   // Outputs
   logic [CHANNELS-1:0]       pwm_q, pwm_d;
   logic                      period_end_q, period_end_d;

   // Per-cycle control
   logic                      tick;
   logic                      boundary;
   logic                      load;
   logic                      wrap;
   logic                      mode_eff;
   logic [WIDTH-1:0]          max_eff;
   logic [CHANNELS*WIDTH-1:0] duty_eff;

   always_comb begin
      // ">=" rather than "==" so that lowering prescale below the running
      // count wraps on the next enabled cycle instead of after 2^N clocks.
      tick = enable && (presc_q >= prescale);

      presc_d = presc_q;
      if (enable) begin
         presc_d = tick ? '0 : presc_q + 1'b1;
      end

      boundary = tick && (cnt_q == '0) && (dir_q == DIR_UP);
      load     = boundary && (pending_q || update);

      // On a loading tick the new values are used straight away.
      mode_eff = load ? mode       : mode_q;
      max_eff  = load ? max        : max_q;
      duty_eff = load ? duty_cycle : duty_q;

      mode_d = mode_eff;
      max_d  = max_eff;
      duty_d = duty_eff;

      if (load) begin
         pending_d = 1'b0;
      end else if (update) begin
         pending_d = 1'b1;
      end else begin
         pending_d = pending_q;
      end

      // Counter sequencing. wrap marks the tick whose successor is the
      // next boundary, i.e. the last tick of the period.
      cnt_d = cnt_q;
      dir_d = dir_q;
      wrap  = 1'b0;
      if (tick) begin
         if (max_eff == '0) begin
            cnt_d = '0;
            dir_d = DIR_UP;
            wrap  = 1'b1;
         end else if (mode_eff == PWM_MODE_EDGE) begin
            dir_d = DIR_UP;
            if (cnt_q >= max_eff) begin
               cnt_d = '0;
               wrap  = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end else begin
            if ((dir_q == DIR_UP) && (cnt_q < max_eff)) begin
               cnt_d = cnt_q + 1'b1;
            end else begin
               // Turning at the top or descending; cnt_q >= 1 here because
               // the bottom of the slope always flips back to counting up.
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == WIDTH'(1)) begin
                  dir_d = DIR_UP;
                  wrap  = 1'b1;
               end else begin
                  dir_d = DIR_DOWN;
               end
            end
         end
      end

      period_end_d = wrap;

      // Compare against the count before it advances: one clk from counter
      // value to pin.
      pwm_d = pwm_q;
      if (tick) begin
         for (int i = 0; i < CHANNELS; i++) begin
            pwm_d[i] = (cnt_q < duty_eff[i*WIDTH +: WIDTH]) ^ polarity[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         presc_q      <= '0;
         cnt_q        <= '0;
         dir_q        <= DIR_UP;
         mode_q       <= PWM_MODE_EDGE;
         max_q        <= '0;
         duty_q       <= '0;
         pending_q    <= 1'b1;
         pwm_q        <= '0;
         period_end_q <= 1'b0;
      end else begin
         presc_q      <= presc_d;
         cnt_q        <= cnt_d;
         dir_q        <= dir_d;
         mode_q       <= mode_d;
         max_q        <= max_d;
         duty_q       <= duty_d;
         pending_q    <= pending_d;
         pwm_q        <= pwm_d;
         period_end_q <= period_end_d;
      end
   end

   assign period_end = period_end_q;

`ifdef REFLET_PWM_MULTI_DEADTIME_EN
   // The dead-time stage registers its own outputs from the next-cycle
   // level, so with dead_time = 0 out keeps the same timing as without it.
   for (genvar g = 0; g < CHANNELS; g++) begin : g_deadtime
      reflet_pwm_multi_deadtime #(
         .WIDTH(WIDTH)
      ) u_deadtime (
         .clk        (clk),
         .reset      (reset),
         .pwm_i      (pwm_d[g]),
         .dead_time_i(dead_time),
         .out_o      (out[g]),
         .out_n_o    (out_n[g])
      );
   end
`else
   assign out = pwm_q;
`endif

endmodule

// File: tb/tb_reflet_pwm_multi.sv
module tb_reflet_pwm_multi;

   localparam int WIDTH = 8;
   localparam int CH    = 4;
   localparam int PW    = 8;

   logic                clk = 1'b0;
   logic                reset;
   logic                enable;
   logic                mode;
   logic [PW-1:0]       prescale;
   logic [WIDTH-1:0]    max_v;
   logic [CH*WIDTH-1:0] duty_cycle;
   logic [CH-1:0]       polarity;
   logic                update;
   logic [CH-1:0]       out;
   logic                period_end;

   always #5 clk = ~clk;

   reflet_pwm_multi #(
      .WIDTH(WIDTH),
      .CHANNELS(CH),
      .PRESCALE_WIDTH(PW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .mode      (mode),
      .prescale  (prescale),
      .max       (max_v),
      .duty_cycle(duty_cycle),
      .polarity  (polarity),
      .update    (update),
      .out       (out),
      .period_end(period_end)
   );

   // ---------------- scoreboard ----------------
   logic [CH:0] exp_q[$];  // {period_end, out} expected after each posedge
   int          n_checks = 0;
   int          n_pass   = 0;
   bit          done     = 1'b0;

   // ---------------- reference model ----------------
   // Works in terms of "ticks since reset" and "position within the period"
   // rather than a counter/direction pair.
   int unsigned m_en_cycles;
   int unsigned m_pos;
   bit          m_pending;
   bit          m_mode;
   int unsigned m_max;
   int unsigned m_duty[CH];
   logic [CH-1:0] m_out;

   function automatic int unsigned period_len(bit md, int unsigned mx);
      if (mx == 0) return 1;
      return md ? 2 * mx : mx + 1;
   endfunction

   // Counter value at a given position within the period.
   function automatic int unsigned count_at(bit md, int unsigned mx, int unsigned pos);
      if (!md) return pos;
      return (pos <= mx) ? pos : 2 * mx - pos;
   endfunction

   always @(posedge clk) begin
      if (!done) begin
         logic [CH:0] e;
         bit          pe;
         bit          loaded;
         int unsigned per;
         int unsigned cv;
         int unsigned pre;
         if (reset) begin
            m_en_cycles = 0;
            m_pos       = 0;
            m_pending   = 1'b1;
            m_mode      = 1'b0;
            m_max       = 0;
            for (int i = 0; i < CH; i++) m_duty[i] = 0;
            m_out = '0;
            e     = '0;
         end else begin
            pe     = 1'b0;
            loaded = 1'b0;
            pre    = prescale;
            if (enable) begin
               if ((m_en_cycles % (pre + 1)) == pre) begin
                  if (m_pos == 0 && (m_pending || update)) begin
                     m_mode = mode;
                     m_max  = max_v;
                     for (int i = 0; i < CH; i++) m_duty[i] = duty_cycle[i*WIDTH +: WIDTH];
                     loaded = 1'b1;
                  end
                  per = period_len(m_mode, m_max);
                  cv  = count_at(m_mode, m_max, m_pos);
                  for (int i = 0; i < CH; i++) m_out[i] = (cv < m_duty[i]) ^ polarity[i];
                  pe    = (m_pos == per - 1);
                  m_pos = (m_pos + 1) % per;
               end
               m_en_cycles++;
            end
            if (loaded) m_pending = 1'b0;
            else if (update) m_pending = 1'b1;
            e = {pe, m_out};
         end
         exp_q.push_back(e);
      end
   end

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (!done) begin
         logic [CH:0] e;
         n_checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL scoreboard_empty t=%0t: got pe=%b out=%b, no expected entry", $time, period_end, out);
         end else begin
            e = exp_q.pop_front();
            if ({period_end, out} === e) begin
               n_pass++;
            end else begin
               $display("FAIL outputs t=%0t: got pe=%b out=%b, required pe=%b out=%b",
                        $time, period_end, out, e[CH], e[CH-1:0]);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step(int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic hard_reset(int pre);
      reset    = 1'b1;
      prescale = pre[PW-1:0];
      step(2);
      reset = 1'b0;
   endtask

   task automatic pulse_update();
      update = 1'b1;
      step(1);
      update = 1'b0;
   endtask

   task automatic set_duty(int ch, int v);
      duty_cycle[ch*WIDTH +: WIDTH] = v[WIDTH-1:0];
   endtask

   task automatic set_cfg(bit md, int mx, int d0, int d1, int d2, int d3);
      mode  = md;
      max_v = mx[WIDTH-1:0];
      set_duty(0, d0);
      set_duty(1, d1);
      set_duty(2, d2);
      set_duty(3, d3);
   endtask

   task automatic random_cycles(int n);
      int mx;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         enable = (($urandom_range(0, 9)) != 0);
         update = (($urandom_range(0, 24)) == 0);
         if ($urandom_range(0, 39) == 0) begin
            mx    = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 12);
            max_v = mx[WIDTH-1:0];
            mode  = $urandom_range(0, 1);
         end
         if ($urandom_range(0, 19) == 0) set_duty($urandom_range(0, CH - 1), $urandom_range(0, 14));
         if ($urandom_range(0, 59) == 0) polarity = $urandom_range(0, 15);
         if ($urandom_range(0, 399) == 0) begin
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
         end
      end
      update = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset      = 1'b1;
      enable     = 1'b0;
      mode       = 1'b0;
      update     = 1'b0;
      prescale   = '0;
      max_v      = '0;
      duty_cycle = '0;
      polarity   = '0;
      step(3);

      // Edge mode, max 9: duty 3, 0, 10 (= max+1), 11.
      hard_reset(0);
      set_cfg(1'b0, 9, 3, 0, 10, 11);
      enable = 1'b1;
      pulse_update();
      step(45);

      // Duty change without update is ignored; with update it takes
      // effect only from the next period.
      set_duty(0, 7);
      step(30);
      step(4);
      pulse_update();
      step(30);

      // Center mode, max 4.
      set_cfg(1'b1, 4, 2, 0, 5, 4);
      pulse_update();
      step(40);

      // Polarity applies on the next tick, no shadowing.
      polarity = 4'b0101;
      step(20);
      polarity = 4'b0000;

      // Prescaled counter with a frozen interval mid-period.
      hard_reset(2);
      set_cfg(1'b0, 9, 3, 5, 0, 12);
      enable = 1'b1;
      pulse_update();
      step(14);
      enable = 1'b0;
      step(5);
      enable = 1'b1;
      step(70);

      // max = 0 in both modes.
      hard_reset(0);
      set_cfg(1'b0, 0, 1, 0, 2, 0);
      enable = 1'b1;
      pulse_update();
      step(10);
      set_cfg(1'b1, 0, 0, 1, 1, 0);
      pulse_update();
      step(10);

      // Center mode with max 1, then reset mid-period.
      set_cfg(1'b1, 1, 1, 2, 0, 1);
      pulse_update();
      step(12);
      set_cfg(1'b0, 6, 4, 4, 4, 4);
      pulse_update();
      step(9);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      step(20);

      // Randomised segments with varying prescale.
      for (int seg = 0; seg < 6; seg++) begin
         hard_reset($urandom_range(0, 3));
         set_cfg($urandom_range(0, 1), $urandom_range(0, 12), $urandom_range(0, 14),
                 $urandom_range(0, 14), $urandom_range(0, 14), $urandom_range(0, 14));
         enable = 1'b1;
         random_cycles(1200);
      end

      @(negedge clk);
      #2 done = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL drain: got %0d leftover expected entries, required 0", exp_q.size());

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
